ram_loader: RTL

- Program-load stage directly upstream of the 16x8 program/data RAM; owns the RAM's address, write-enable and write-data inputs.
- In normal run it passes the CPU's memory-address/write path through to the RAM unchanged.
- On request it halts the CPU and accepts a 16-byte image plus one checksum byte over a valid/ready byte stream (e.g. from UART RX), writing the image into RAM sequentially.
- It then reads the whole RAM back through the RAM's synchronous read port to verify contents, and reports done or error.

---
 rtl/ram_loader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// Program-load stage in front of the 16x8 program/data RAM.
// Passes the CPU memory path through when idle. On start, halts the CPU,
// streams a DEPTH-byte image plus a checksum byte into RAM, then reads the
// RAM back and re-sums it to confirm the contents before raising done/error.
module ram_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra bit so the counter can reach DEPTH (checksum slot / last verify cycle).
  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   sum_reg, sum_next;
  logic [DATA_W-1:0]   ck_reg, ck_next;
  logic                done_reg, done_next;
  logic                error_reg, error_next;

  logic                addr_phase;
  logic [DATA_W-1:0]   sum_plus_rx;
  logic [DATA_W-1:0]   sum_plus_rd;

  // Modulo-2**DATA_W sums; the carry simply falls off the top.
  assign addr_phase  = (cnt_reg < CNT_DEPTH);
  assign sum_plus_rx = sum_reg + rx_data;
  assign sum_plus_rd = sum_reg + ram_rdata;

  assign cpu_halt = busy;
  assign done     = done_reg;
  assign error    = error_reg;

  // Next-state, datapath updates and RAM-port steering.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum_reg;
    ck_next    = ck_reg;
    done_next  = done_reg;
    error_next = error_reg;
    ram_addr   = cpu_addr;
    ram_we     = cpu_we;
    ram_wdata  = cpu_wdata;
    rx_ready   = 1'b0;
    busy       = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next = S_LOAD;
          cnt_next   = '0;
          sum_next   = '0;
          done_next  = 1'b0;
          error_next = 1'b0;
        end
      end

      S_LOAD: begin
        busy      = 1'b1;
        rx_ready  = 1'b1;
        ram_addr  = cnt_reg[ADDR_W-1:0];
        ram_wdata = rx_data;
        ram_we    = rx_valid && addr_phase;
        // rx_ready is always high here, so a valid byte is an accepted byte.
        if (rx_valid) begin
          sum_next = sum_plus_rx;
          if (addr_phase) begin
            cnt_next = cnt_reg + 1'b1;
          end else begin
            // Checksum byte: kept, never written to RAM.
            ck_next = rx_data;
            if (sum_plus_rx != '0) begin
              state_next = S_ERROR;
              error_next = 1'b1;
            end else begin
              // Re-seed with the checksum so the read-back sum must also hit zero.
              state_next = S_VERIFY;
              cnt_next   = '0;
              sum_next   = rx_data;
            end
          end
        end
      end

      S_VERIFY: begin
        busy      = 1'b1;
        ram_we    = 1'b0;
        ram_wdata = '0;
        ram_addr  = cnt_reg[ADDR_W-1:0];
        cnt_next  = cnt_reg + 1'b1;
        // Read data lags the address by one cycle, so cycle 0 has nothing to add.
        if (cnt_reg != '0) begin
          sum_next = sum_plus_rd;
        end
        if (cnt_reg == CNT_DEPTH) begin
          if (sum_plus_rd == '0) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = S_ERROR;
            error_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any load in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      ck_reg    <= '0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sum_reg   <= sum_next;
      ck_reg    <= ck_next;
      done_reg  <= done_next;
      error_reg <= error_next;
    end
  end

endmodule
